// File: rtl/gpio_bus_master.sv
// Single-outstanding initiator for the valid/ready peripheral bus: takes one
// command, holds it on the bus until ready or timeout, then returns a response.
module gpio_bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  // Command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_ctrl,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  // Response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // Peripheral bus
  output logic        valid,
  input  logic        ready,
  output logic        ctrl,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [31:0] rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

  // Abort fires on the last of TIMEOUT request cycles (counter starts at 0).
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        ctrl_q, ctrl_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  always_comb begin
    // NOTE: every target is defaulted to its held value first, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ctrl_d  = cmd_ctrl;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_write ? cmd_wstrb : 4'b0000;
          cnt_d   = '0;
          valid_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // ready takes priority over a timeout landing on the same edge.
        if (ready) begin
          rsp_rdata_d = rdata;
          rsp_err_d   = 1'b0;
          valid_d     = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (cnt_q == TMO_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          valid_d     = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        valid_d     = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign valid     = valid_q;
  assign ctrl      = ctrl_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gpio_bus_master.sv
// Bench for gpio_bus_master: a small GPIO-like responder with programmable
// ready delay, a vector table of transactions, and hand-written corner cases.
module tb_gpio_bus_master;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_ctrl;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        valid, ready, ctrl;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  gpio_bus_master #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_ctrl  (cmd_ctrl),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .valid     (valid),
    .ready     (ready),
    .ctrl      (ctrl),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .rdata     (rdata)
  );

  // Responder: uo_out at ctrl=0, uo_en at ctrl=1. ready is raised so that it is
  // sampled in the resp_k-th request cycle (resp_k=0: never answer).
  logic [31:0] uo_out, uo_en;
  logic        model_ready, ready_force;
  int          resp_k, vcnt;

  assign ready = model_ready | ready_force;
  assign rdata = ctrl ? uo_en : uo_out;

  always @(posedge clk) begin
    if (!resetn) begin
      uo_out      <= '0;
      uo_en       <= '0;
      model_ready <= 1'b0;
      vcnt        <= 0;
    end else begin
      if (valid && ready) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) begin
            if (ctrl) uo_en[8*b +: 8]  <= wdata[8*b +: 8];
            else      uo_out[8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
      if (valid && !model_ready) begin
        vcnt        <= vcnt + 1;
        model_ready <= (resp_k >= 2) && (vcnt + 2 == resp_k);
      end else begin
        model_ready <= 1'b0;
        if (!valid) vcnt <= 0;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic        csel;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          k;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_bus_wstrb;
    int          exp_lat;
    logic [31:0] exp_out;
    logic [31:0] exp_en;
  } vec_t;

  vec_t vecs[9];

  task automatic run_txn(input vec_t v);
    int lat;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_ctrl  = v.csel;
    cmd_wdata = v.wd;
    cmd_wstrb = v.ws;
    resp_k    = v.k;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      check("req_valid", 32'(valid), 32'd1);
      check("req_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bus_ctrl", 32'(ctrl), 32'(v.csel));
      check("bus_wdata", wdata, v.wd);
      check("bus_wstrb", 32'(wstrb), 32'(v.exp_bus_wstrb));
      lat++;
      @(negedge clk);
    end
    check("latency", lat, v.exp_lat);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("valid_low_in_rsp", 32'(valid), 32'd0);
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_consumed", 32'(rsp_valid), 32'd0);
    check("cmd_ready_back", 32'(cmd_ready), 32'd1);
    check("gpio_uo_out", uo_out, v.exp_out);
    check("gpio_uo_en", uo_en, v.exp_en);
  endtask

  initial begin
    int n;
    //          wr    sel   wdata          wstrb k  rdata         err   bus_ws lat out            en
    vecs[0] = '{1'b1, 1'b0, 32'h0000_00A5, 4'h1, 2, 32'h0000_0000, 1'b0, 4'h1, 2,  32'h0000_00A5, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_003C, 4'hF, 2, 32'h0000_0000, 1'b0, 4'hF, 2,  32'h0000_00A5, 32'h0000_003C};
    vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 2, 32'h0000_003C, 1'b0, 4'h0, 2,  32'h0000_00A5, 32'h0000_003C};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0000, 4'h0, 5, 32'h0000_00A5, 1'b0, 4'h0, 5,  32'h0000_00A5, 32'h0000_003C};
    vecs[4] = '{1'b1, 1'b0, 32'h1234_5678, 4'h0, 2, 32'h0000_00A5, 1'b0, 4'h0, 2,  32'h0000_00A5, 32'h0000_003C};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_FF00, 4'h2, 3, 32'h0000_00A5, 1'b0, 4'h2, 3,  32'h0000_FFA5, 32'h0000_003C};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 4'h0, 0, 32'h0000_0000, 1'b1, 4'h0, 8,  32'h0000_FFA5, 32'h0000_003C};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0000, 4'h0, 8, 32'h0000_FFA5, 1'b0, 4'h0, 8,  32'h0000_FFA5, 32'h0000_003C};
    vecs[8] = '{1'b0, 1'b1, 32'h0000_0000, 4'h0, 7, 32'h0000_003C, 1'b0, 4'h0, 7,  32'h0000_FFA5, 32'h0000_003C};

    resetn      = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_ctrl    = 1'b0;
    cmd_wdata   = '0;
    cmd_wstrb   = '0;
    rsp_ready   = 1'b0;
    ready_force = 1'b0;
    resp_k      = 0;
    repeat (3) @(negedge clk);

    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_wstrb", 32'(wstrb), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Stray ready pulses while idle must not start or complete anything.
    @(negedge clk);
    ready_force = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready_valid", 32'(valid), 32'd0);
    check("idle_ready_rsp", 32'(rsp_valid), 32'd0);
    check("idle_ready_cmd_ready", 32'(cmd_ready), 32'd1);
    ready_force = 1'b0;

    // Response backpressure with a new command already waiting.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_ctrl  = 1'b1;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    resp_k    = 2;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    ready_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_valid", 32'(valid), 32'd0);
      check("bp_rsp_hold", 32'(rsp_valid), 32'd1);
      check("bp_rdata_stable", rsp_rdata, 32'h0000_003C);
      check("bp_err_stable", 32'(rsp_err), 32'd0);
      @(negedge clk);
    end
    ready_force = 1'b0;
    rsp_ready   = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b_gap_valid", 32'(valid), 32'd0);
    check("b2b_gap_rsp", 32'(rsp_valid), 32'd0);
    check("b2b_gap_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_next_valid", 32'(valid), 32'd1);
    check("b2b_next_cmd_ready", 32'(cmd_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
    check("b2b_rsp_rdata", rsp_rdata, 32'h0000_003C);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset while a request is outstanding.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_ctrl  = 1'b0;
    resp_k    = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rreq_valid_before", 32'(valid), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rreq_valid_dropped", 32'(valid), 32'd0);
    check("rreq_no_rsp", 32'(rsp_valid), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rreq_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rreq_rsp_err", 32'(rsp_err), 32'd0);
    repeat (TMO + 2) @(negedge clk);
    check("rreq_no_late_rsp", 32'(rsp_valid), 32'd0);
    check("rreq_idle_valid", 32'(valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
